// File: rtl/banana_pkg.sv
// Shared types and default sizing for the banana launch scheduler.
package banana_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECT,
        ST_LAUNCH,
        ST_COOLDOWN
    } sched_state_t;

    localparam int NUM_SLOTS       = 4;
    localparam int COOLDOWN_FRAMES = 8;
    localparam int LIFETIME_FRAMES = 90;
    localparam int LAUNCH_TIMEOUT  = 255;

endpackage

// File: rtl/banana_slot_tracker.sv
// One banana slot: lifetime countdown and the held monster_collision retire request.
module banana_slot_tracker
    import banana_pkg::*;
#(
    parameter int LIFETIME_FRAMES = banana_pkg::LIFETIME_FRAMES
) (
    input  logic clk,
    input  logic resetN,
    input  logic start_of_frame,
    input  logic game_enable,
    input  logic active,
    input  logic hit,
    input  logic load,
    output logic retire
);

    localparam int LT_W = (LIFETIME_FRAMES > 0) ? $clog2(LIFETIME_FRAMES + 1) : 1;

    logic [LT_W-1:0] life_cnt;
    logic            expire;

    // Expiry fires on the frame that takes the count to zero (or finds it already there).
    assign expire = start_of_frame && !retire && !load && (life_cnt <= LT_W'(1));

    always_ff @(posedge clk) begin
        if (resetN) begin
            life_cnt <= '0;
            retire   <= 1'b0;
        end else begin
            if (load)
                life_cnt <= LT_W'(LIFETIME_FRAMES);
            else if (start_of_frame && active && !retire && life_cnt != '0)
                life_cnt <= life_cnt - LT_W'(1);

            if (!active)
                retire <= 1'b0;
            else if (hit || !game_enable || expire)
                retire <= 1'b1;
        end
    end

endmodule

// File: rtl/banana_launch_scheduler.sv
// Fire-request FSM: picks a free banana slot, runs the appear/active handshake, enforces cooldown.
module banana_launch_scheduler
    import banana_pkg::*;
#(
    parameter int NUM_SLOTS       = banana_pkg::NUM_SLOTS,
    parameter int COOLDOWN_FRAMES = banana_pkg::COOLDOWN_FRAMES,
    parameter int LIFETIME_FRAMES = banana_pkg::LIFETIME_FRAMES,
    parameter int LAUNCH_TIMEOUT  = banana_pkg::LAUNCH_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 game_enable,
    input  logic                 fire_req,
    input  logic [10:0]          fire_y,
    input  logic [NUM_SLOTS-1:0] slot_active,
    input  logic [NUM_SLOTS-1:0] slot_hit,
    output logic [NUM_SLOTS-1:0] appear,
    output logic [10:0]          initial_y,
    output logic [NUM_SLOTS-1:0] monster_collision,
    output logic                 fire_ack,
    output logic                 fire_denied,
    output logic [7:0]           shots_fired
);

    localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    sched_state_t         state;
    logic [IDX_W-1:0]     sel_idx;
    logic [CD_W-1:0]      cd_cnt;
    logic [7:0]           to_cnt;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic                 confirm;
    logic [NUM_SLOTS-1:0] launch_load;

    // Lowest-index slot that is neither flying nor still being retired.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i] && !monster_collision[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign confirm     = game_enable && (state == ST_LAUNCH) && slot_active[sel_idx];
    assign launch_load = confirm ? (NUM_SLOTS'(1) << sel_idx) : '0;

    always_ff @(posedge clk) begin
        if (resetN) begin
            state       <= ST_IDLE;
            sel_idx     <= '0;
            cd_cnt      <= '0;
            to_cnt      <= '0;
            appear      <= '0;
            initial_y   <= '0;
            fire_ack    <= 1'b0;
            fire_denied <= 1'b0;
            shots_fired <= '0;
        end else begin
            fire_ack    <= 1'b0;
            fire_denied <= 1'b0;
            if (!game_enable) begin
                state  <= ST_IDLE;
                appear <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fire_req) begin
                            initial_y <= fire_y;
                            state     <= ST_SELECT;
                        end
                    end
                    ST_SELECT: begin
                        if (free_found) begin
                            sel_idx <= free_idx;
                            appear  <= NUM_SLOTS'(1) << free_idx;
                            to_cnt  <= '0;
                            state   <= ST_LAUNCH;
                        end else begin
                            fire_denied <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                    ST_LAUNCH: begin
                        if (slot_active[sel_idx]) begin
                            appear   <= '0;
                            fire_ack <= 1'b1;
                            if (shots_fired != 8'hFF)
                                shots_fired <= shots_fired + 8'd1;
                            cd_cnt <= CD_W'(COOLDOWN_FRAMES);
                            state  <= (COOLDOWN_FRAMES == 0) ? ST_IDLE : ST_COOLDOWN;
                        end else if (to_cnt == 8'(LAUNCH_TIMEOUT - 1)) begin
                            appear      <= '0;
                            fire_denied <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            to_cnt <= to_cnt + 8'd1;
                        end
                    end
                    ST_COOLDOWN: begin
                        if (cd_cnt == '0)
                            state <= ST_IDLE;
                        else if (startOfFrame)
                            cd_cnt <= cd_cnt - CD_W'(1);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        banana_slot_tracker #(
            .LIFETIME_FRAMES(LIFETIME_FRAMES)
        ) u_trk (
            .clk           (clk),
            .resetN        (resetN),
            .start_of_frame(startOfFrame),
            .game_enable   (game_enable),
            .active        (slot_active[g]),
            .hit           (slot_hit[g]),
            .load          (launch_load[g]),
            .retire        (monster_collision[g])
        );
    end

endmodule

// File: tb/tb_banana_launch_scheduler.sv
// Scenario bench for banana_launch_scheduler with a lowest-free-slot reference model.
module tb_banana_launch_scheduler;

    localparam int NS = 4;
    localparam int CD = 8;
    localparam int LT = 90;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          resetN, startOfFrame, game_enable, fire_req;
    logic [10:0]   fire_y;
    logic [NS-1:0] slot_active, slot_hit;
    logic [NS-1:0] appear, monster_collision;
    logic [10:0]   initial_y;
    logic          fire_ack, fire_denied;
    logic [7:0]    shots_fired;

    int errors = 0;
    int checks = 0;

    banana_launch_scheduler dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .game_enable(game_enable),
        .fire_req(fire_req), .fire_y(fire_y), .slot_active(slot_active), .slot_hit(slot_hit),
        .appear(appear), .initial_y(initial_y), .monster_collision(monster_collision),
        .fire_ack(fire_ack), .fire_denied(fire_denied), .shots_fired(shots_fired)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        resetN = 1'b1; startOfFrame = 1'b0; game_enable = 1'b1; fire_req = 1'b0;
        fire_y = '0; slot_active = '0; slot_hit = '0;
        tick(2);
        resetN = 1'b0;
    endtask

    // Request accepted at the first edge; appear/denied visible after the second.
    task automatic fire(input logic [10:0] y);
        fire_y = y; fire_req = 1'b1;
        tick();
        fire_req = 1'b0;
        tick();
    endtask

    function automatic logic [NS-1:0] model_pick(input logic [NS-1:0] busy);
        logic [NS-1:0] r;
        r = '0;
        for (int i = 0; i < NS; i++)
            if (!busy[i] && r == '0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (appear !== '0 || monster_collision !== '0) begin
            errors++; $display("FAIL reset_slots: appear=%b mc=%b want 0", appear, monster_collision); end
        checks++; if ({fire_ack, fire_denied} !== 2'b00) begin
            errors++; $display("FAIL reset_pulses: ack=%b den=%b want 0", fire_ack, fire_denied); end
        checks++; if (initial_y !== 11'd0 || shots_fired !== 8'd0) begin
            errors++; $display("FAIL reset_regs: y=%0d shots=%0d want 0", initial_y, shots_fired); end
    endtask

    task automatic test_launch();
        do_reset();
        fire(11'd200);
        checks++; if (appear !== model_pick('0)) begin
            errors++; $display("FAIL launch_appear: got %b want %b", appear, model_pick('0)); end
        checks++; if (initial_y !== 11'd200) begin
            errors++; $display("FAIL launch_y: got %0d want 200", initial_y); end
        tick(2);
        checks++; if (appear !== 4'b0001 || fire_ack !== 1'b0) begin
            errors++; $display("FAIL launch_hold: appear=%b ack=%b want 0001/0", appear, fire_ack); end
        slot_active[0] = 1'b1;
        tick();
        checks++; if (fire_ack !== 1'b1 || appear !== '0 || shots_fired !== 8'd1) begin
            errors++; $display("FAIL launch_ack: ack=%b appear=%b shots=%0d want 1/0000/1", fire_ack, appear, shots_fired); end
        tick();
        checks++; if (fire_ack !== 1'b0) begin
            errors++; $display("FAIL launch_ack_pulse: got %b want 0", fire_ack); end
    endtask

    task automatic test_cooldown();
        int bad;
        do_reset();
        slot_active = 4'b0011;
        fire(11'd17);
        checks++; if (appear !== model_pick(4'b0011)) begin
            errors++; $display("FAIL cd_appear: got %b want %b", appear, model_pick(4'b0011)); end
        slot_active[2] = 1'b1;
        tick();
        checks++; if (fire_ack !== 1'b1) begin
            errors++; $display("FAIL cd_ack: got %b want 1", fire_ack); end
        fire_y = 11'd33; fire_req = 1'b1; bad = 0;
        for (int f = 0; f < CD; f++) begin
            startOfFrame = 1'b1;
            tick();
            if (appear !== '0 || fire_ack || fire_denied) bad++;
            startOfFrame = 1'b0;
            tick();
            if (appear !== '0 || fire_ack || fire_denied) bad++;
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL cd_dropped: %0d cycles with activity want 0", bad); end
        checks++; if (initial_y !== 11'd17) begin
            errors++; $display("FAIL cd_y_hold: got %0d want 17", initial_y); end
        tick();
        fire_req = 1'b0;
        tick();
        checks++; if (appear !== model_pick(4'b0111) || initial_y !== 11'd33) begin
            errors++; $display("FAIL cd_reaccept: appear=%b y=%0d want %b/33", appear, initial_y, model_pick(4'b0111)); end
    endtask

    task automatic test_all_busy();
        do_reset();
        slot_active = 4'b1111;
        fire(11'd5);
        checks++; if (fire_denied !== 1'b1 || appear !== '0) begin
            errors++; $display("FAIL busy_deny: den=%b appear=%b want 1/0000", fire_denied, appear); end
        tick();
        checks++; if (fire_denied !== 1'b0 || shots_fired !== 8'd0) begin
            errors++; $display("FAIL busy_pulse: den=%b shots=%0d want 0/0", fire_denied, shots_fired); end
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        fire(11'd9);
        checks++; if (appear !== 4'b0001) begin
            errors++; $display("FAIL to_appear: got %b want 0001", appear); end
        cnt = 0;
        while (appear !== '0 && cnt < 400) begin
            cnt++;
            tick();
        end
        checks++; if (cnt != TO) begin
            errors++; $display("FAIL to_len: appear high %0d clocks want %0d", cnt, TO); end
        checks++; if (fire_denied !== 1'b1) begin
            errors++; $display("FAIL to_deny: got %b want 1", fire_denied); end
        tick();
        checks++; if (fire_denied !== 1'b0) begin
            errors++; $display("FAIL to_deny_pulse: got %b want 0", fire_denied); end
        fire(11'd10);
        checks++; if (appear !== 4'b0001) begin
            errors++; $display("FAIL to_idle: got %b want 0001", appear); end
        resetN = 1'b1;
        tick();
        checks++; if (appear !== '0) begin
            errors++; $display("FAIL reset_mid_launch: got %b want 0000", appear); end
        resetN = 1'b0;
    endtask

    task automatic test_retire();
        do_reset();
        slot_hit = 4'b0010;
        tick();
        checks++; if (monster_collision !== '0) begin
            errors++; $display("FAIL hit_inactive: got %b want 0000", monster_collision); end
        slot_active = 4'b0100; slot_hit = 4'b0100;
        tick();
        slot_hit = '0;
        checks++; if (monster_collision !== 4'b0100) begin
            errors++; $display("FAIL hit_set: got %b want 0100", monster_collision); end
        tick(5);
        checks++; if (monster_collision !== 4'b0100) begin
            errors++; $display("FAIL hit_hold: got %b want 0100", monster_collision); end
        slot_active = '0;
        tick();
        checks++; if (monster_collision !== '0) begin
            errors++; $display("FAIL hit_clear: got %b want 0000", monster_collision); end
        // Lifetime expiry on slot 0.
        fire(11'd1);
        slot_active[0] = 1'b1;
        tick();
        checks++; if (fire_ack !== 1'b1) begin
            errors++; $display("FAIL life_ack: got %b want 1", fire_ack); end
        for (int f = 1; f <= LT; f++) begin
            sof_pulse();
            if (f == LT - 1) begin
                checks++; if (monster_collision[0] !== 1'b0) begin
                    errors++; $display("FAIL life_early: frame %0d got 1 want 0", f); end
            end
        end
        checks++; if (monster_collision[0] !== 1'b1) begin
            errors++; $display("FAIL life_expire: got %b want 1", monster_collision[0]); end
        slot_active[0] = 1'b0;
        tick();
        checks++; if (monster_collision !== '0) begin
            errors++; $display("FAIL life_clear: got %b want 0000", monster_collision); end
    endtask

    task automatic test_game_disable();
        do_reset();
        slot_active = 4'b1010;
        fire(11'd44);
        checks++; if (appear !== model_pick(4'b1010)) begin
            errors++; $display("FAIL ge_appear: got %b want %b", appear, model_pick(4'b1010)); end
        game_enable = 1'b0;
        tick();
        checks++; if (appear !== '0 || monster_collision !== 4'b1010) begin
            errors++; $display("FAIL ge_drop: appear=%b mc=%b want 0000/1010", appear, monster_collision); end
        fire_req = 1'b1;
        tick(3);
        fire_req = 1'b0;
        checks++; if (appear !== '0 || fire_denied !== 1'b0) begin
            errors++; $display("FAIL ge_ignore: appear=%b den=%b want 0000/0", appear, fire_denied); end
        resetN = 1'b1;
        tick();
        checks++; if ({appear, monster_collision, fire_ack, fire_denied, initial_y, shots_fired} !== '0) begin
            errors++; $display("FAIL ge_reset: appear=%b mc=%b y=%0d shots=%0d want all 0", appear, monster_collision, initial_y, shots_fired); end
        resetN = 1'b0; game_enable = 1'b1;
    endtask

    task automatic test_random();
        logic [NS-1:0] mask, exp;
        logic [10:0]   y;
        bit            hit_too;
        for (int t = 0; t < 24; t++) begin
            do_reset();
            mask = NS'($urandom_range(0, (1 << NS) - 1));
            y = 11'($urandom_range(0, 2047));
            slot_active = mask;
            fire(y);
            exp = model_pick(mask);
            if (exp == '0) begin
                checks++; if (fire_denied !== 1'b1 || appear !== '0) begin
                    errors++; $display("FAIL rnd_deny: mask=%b den=%b appear=%b", mask, fire_denied, appear); end
            end else begin
                checks++; if (appear !== exp) begin
                    errors++; $display("FAIL rnd_pick: mask=%b got %b want %b", mask, appear, exp); end
                tick($urandom_range(0, 5));
                hit_too = 1'($urandom_range(0, 1));
                slot_active = mask | exp;
                slot_hit = hit_too ? exp : '0;
                tick();
                slot_hit = '0;
                checks++; if (fire_ack !== 1'b1 || shots_fired !== 8'd1 || initial_y !== y) begin
                    errors++; $display("FAIL rnd_ack: ack=%b shots=%0d y=%0d want 1/1/%0d", fire_ack, shots_fired, initial_y, y); end
                checks++; if (monster_collision !== (hit_too ? exp : '0)) begin
                    errors++; $display("FAIL rnd_hit_confirm: mc=%b want %b", monster_collision, hit_too ? exp : '0); end
            end
        end
    endtask

    task automatic test_saturate();
        int model;
        do_reset();
        model = 0;
        for (int n = 1; n <= 260; n++) begin
            fire(11'(n));
            slot_active = 4'b0001;
            tick();
            slot_active = '0;
            if (model < 255) model++;
            checks++; if (shots_fired !== 8'(model) || fire_ack !== 1'b1) begin
                errors++; $display("FAIL sat_count: launch %0d shots=%0d ack=%b want %0d/1", n, shots_fired, fire_ack, model); end
            tick();
            repeat (CD) sof_pulse();
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_cooldown();
        test_all_busy();
        test_timeout();
        test_retire();
        test_game_disable();
        test_random();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
